// File: rtl/pipe_arith_hs.sv
// Three-stage pipelined F = (A+B) <op> (C-D) with valid/ready flow control,
// optional saturation, per-result overflow flag and a delivered-result counter.
module pipe_arith_hs #(
   parameter int WIDTH = 10,
   parameter int SAT   = 0,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [WIDTH-1:0] C,
   input  logic [WIDTH-1:0] D,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] F,
   output logic             ovf,
   output logic [CNT_W-1:0] count
);

   localparam logic [WIDTH-1:0] MAXV = {WIDTH{1'b1}};
   localparam bit               SATB = (SAT != 0);

   // Handshake: a transfer happens on an edge where valid & ready are both high.
   // in_ready is low only while the output holds an unaccepted result; then the
   // whole pipe freezes, so the source must keep its transaction until in_ready.
   logic stall, advance;

   logic [WIDTH-1:0]   s1_q, s1_d, s2_q, s2_d;
   logic [1:0]         op1_q, op1_d;
   logic               ovf1_q, ovf1_d, v1_q, v1_d;

   logic [2*WIDTH-1:0] r2_q, r2_d;
   logic               neg2_q, neg2_d, ovf2_q, ovf2_d, v2_q, v2_d;

   logic [WIDTH-1:0]   f_q, f_d;
   logic               ovf3_q, ovf3_d, v3_q, v3_d;
   logic [CNT_W-1:0]   count_q, count_d;

   logic [WIDTH:0]     sum_w, add_w;
   logic [WIDTH-1:0]   diff_w, sub_w;
   logic               borrow_w, neg_w, hi_nz;
   logic [2*WIDTH-1:0] prod_w;

   assign stall    = v3_q & ~out_ready;
   assign advance  = ~stall;
   assign in_ready = advance;

   always_comb begin
      sum_w    = {1'b0, A} + {1'b0, B};
      diff_w   = C - D;
      borrow_w = (C < D);
      s1_d     = s1_q;
      s2_d     = s2_q;
      op1_d    = op1_q;
      ovf1_d   = ovf1_q;
      v1_d     = v1_q;
      if (advance) begin
         v1_d   = in_valid;
         s1_d   = (SATB && sum_w[WIDTH]) ? MAXV : sum_w[WIDTH-1:0];
         s2_d   = (SATB && borrow_w) ? '0 : diff_w;
         op1_d  = op;
         ovf1_d = sum_w[WIDTH] | borrow_w;
      end
   end

   // Stage 2 keeps the full-width result; truncation or clamping happens in stage 3.
   always_comb begin
      prod_w = {{WIDTH{1'b0}}, s1_q} * {{WIDTH{1'b0}}, s2_q};
      add_w  = {1'b0, s1_q} + {1'b0, s2_q};
      sub_w  = s1_q - s2_q;
      neg_w  = (s1_q < s2_q);
      r2_d   = r2_q;
      neg2_d = neg2_q;
      ovf2_d = ovf2_q;
      v2_d   = v2_q;
      if (advance) begin
         v2_d   = v1_q;
         ovf2_d = ovf1_q;
         neg2_d = 1'b0;
         case (op1_q)
            2'b00: r2_d = prod_w;
            2'b01: r2_d = {{(WIDTH-1){1'b0}}, add_w};
            2'b10: begin
               r2_d   = {{WIDTH{1'b0}}, sub_w};
               neg2_d = neg_w;
            end
            default: r2_d = {{WIDTH{1'b0}}, s1_q ^ s2_q};
         endcase
      end
   end

   always_comb begin
      hi_nz   = |r2_q[2*WIDTH-1:WIDTH];
      f_d     = f_q;
      ovf3_d  = ovf3_q;
      v3_d    = v3_q;
      count_d = count_q + {{(CNT_W-1){1'b0}}, (v3_q & out_ready)};
      if (advance) begin
         v3_d   = v2_q;
         ovf3_d = ovf2_q | neg2_q | hi_nz;
         if (SATB && neg2_q)
            f_d = '0;
         else if (SATB && hi_nz)
            f_d = MAXV;
         else
            f_d = r2_q[WIDTH-1:0];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q    <= '0;
         s2_q    <= '0;
         op1_q   <= '0;
         ovf1_q  <= 1'b0;
         v1_q    <= 1'b0;
         r2_q    <= '0;
         neg2_q  <= 1'b0;
         ovf2_q  <= 1'b0;
         v2_q    <= 1'b0;
         f_q     <= '0;
         ovf3_q  <= 1'b0;
         v3_q    <= 1'b0;
         count_q <= '0;
      end else begin
         s1_q    <= s1_d;
         s2_q    <= s2_d;
         op1_q   <= op1_d;
         ovf1_q  <= ovf1_d;
         v1_q    <= v1_d;
         r2_q    <= r2_d;
         neg2_q  <= neg2_d;
         ovf2_q  <= ovf2_d;
         v2_q    <= v2_d;
         f_q     <= f_d;
         ovf3_q  <= ovf3_d;
         v3_q    <= v3_d;
         count_q <= count_d;
      end
   end

   assign out_valid = v3_q;
   assign F         = f_q;
   assign ovf       = ovf3_q;
   assign count     = count_q;

endmodule
